corr_search_ctrl: RTL

//  Parametrised raster-search controller for the template-correlation engine. Once a frame
//  is buffered it walks (X,Y) over a configurable grid with configurable step, requests one

---
 rtl/corr_search_ctrl_if.sv | 25 ++
 rtl/corr_search_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/corr_search_ctrl_if.sv
// Purpose : point-request / result handshake between the raster-search controller and the correlation datapath.
// Latency : wires only; the timing belongs to the two endpoints.
// Backpressure: none. The master holds oX/oY until a result returns, and the slave answers each oCorrStart with exactly one iCorrValid.
// Signals : oCorrStart (1-cycle request), oX/oY (search point), iCorrValid (1-cycle result strobe), iCurrentCorr (unsigned result).
// Modports: master = search controller, slave = correlation datapath.
interface corr_search_ctrl_if #(
  parameter int COORD_W = 13,
  parameter int CORR_W  = 32
) ();
  logic               oCorrStart;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic               iCorrValid;
  logic [CORR_W-1:0]  iCurrentCorr;

  modport master (
    output oCorrStart, oX, oY,
    input  iCorrValid, iCurrentCorr
  );

  modport slave (
    input  oCorrStart, oX, oY,
    output iCorrValid, iCurrentCorr
  );
endinterface

// File: rtl/corr_search_ctrl.sv
// Purpose : raster-search controller. It walks (X,Y) over a stepped grid, requests one correlation per point and tracks the maximum.
// Latency : oCorrStart goes high 1 cycle after iStart is accepted. Each point takes 2 cycles plus the datapath wait cycles.
// Backpressure: waits in WAIT until iCorrValid arrives. Dropping iFrameDone aborts to IDLE on the next edge.
// Ports   : iCLK, iRST_N (async, active-low), iFrameDone (level), iStart (pulse), corrBus (master: oCorrStart/oX/oY out,
//           iCorrValid/iCurrentCorr in), oBusy, oXresult/oYresult/oBestCorr (best point), oFinished (whole grid done),
//           oStatusLed (heartbeat while busy, solid in DONE).
// Option  : CORR_SECOND_BEST_EN adds runner-up tracking on oSecondCorr/oXsecond/oYsecond.
module corr_search_ctrl #(
  parameter int COORD_W = 13,
  parameter int CORR_W  = 32,
  parameter int X_LAST  = 799,
  parameter int Y_LAST  = 599,
  parameter int X_STEP  = 1,
  parameter int Y_STEP  = 1,
  parameter int HB_BITS = 25
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iFrameDone,
  input  logic                iStart,
  corr_search_ctrl_if.master  corrBus,
  output logic                oBusy,
  output logic [COORD_W-1:0]  oXresult,
  output logic [COORD_W-1:0]  oYresult,
  output logic [CORR_W-1:0]   oBestCorr,
  output logic                oFinished,
  output logic                oStatusLed
`ifdef CORR_SECOND_BEST_EN
 ,output logic [CORR_W-1:0]   oSecondCorr,
  output logic [COORD_W-1:0]  oXsecond,
  output logic [COORD_W-1:0]  oYsecond
`endif
);

  // The step arithmetic uses one extra bit so that a step past the last
  // coordinate cannot wrap back into the grid.
  localparam int EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] X_LAST_E = EXT_W'(X_LAST);
  localparam logic [EXT_W-1:0] Y_LAST_E = EXT_W'(Y_LAST);
  localparam logic [EXT_W-1:0] X_STEP_E = EXT_W'(X_STEP);
  localparam logic [EXT_W-1:0] Y_STEP_E = EXT_W'(Y_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t stateNext;

  logic [COORD_W-1:0] xCur;
  logic [COORD_W-1:0] yCur;
  logic [EXT_W-1:0]   nextX;
  logic [EXT_W-1:0]   nextY;
  logic [COORD_W-1:0] xBest;
  logic [COORD_W-1:0] yBest;
  logic [CORR_W-1:0]  bestCorr;
  logic [HB_BITS-1:0] hbCnt;

  // Control strobes from the FSM to the datapath registers.
  logic sweepStart;
  logic capture;
  logic advX;
  logic advY;
  logic busy;
  logic newBest;

  assign nextX   = {1'b0, xCur} + X_STEP_E;
  assign nextY   = {1'b0, yCur} + Y_STEP_E;
  assign busy    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_STEP);
  // The comparison is strict, so a tie keeps the earlier point in raster order.
  assign newBest = corrBus.iCurrentCorr > bestCorr;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = state;
    sweepStart = 1'b0;
    capture    = 1'b0;
    advX       = 1'b0;
    advY       = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart && iFrameDone) begin
          sweepStart = 1'b1;
          stateNext  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // oCorrStart is high for this single cycle only.
        if (!iFrameDone) stateNext = S_IDLE;
        else             stateNext = S_WAIT;
      end
      S_WAIT: begin
        // If the frame is lost, abort takes priority. A result that arrives
        // in that same cycle belongs to an invalid sweep and is dropped.
        if (!iFrameDone) begin
          stateNext = S_IDLE;
        end else if (corrBus.iCorrValid) begin
          capture   = 1'b1;
          stateNext = S_STEP;
        end
      end
      S_STEP: begin
        if (!iFrameDone) begin
          stateNext = S_IDLE;
        end else if (nextX <= X_LAST_E) begin
          advX      = 1'b1;
          stateNext = S_ISSUE;
        end else if (nextY <= Y_LAST_E) begin
          advY      = 1'b1;
          stateNext = S_ISSUE;
        end else begin
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (!iFrameDone) begin
          stateNext = S_IDLE;
        end else if (iStart) begin
          sweepStart = 1'b1;
          stateNext  = S_ISSUE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Search point. It holds from ISSUE until STEP moves it on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xCur <= '0;
      yCur <= '0;
    end else if (sweepStart) begin
      xCur <= '0;
      yCur <= '0;
    end else if (advX) begin
      xCur <= nextX[COORD_W-1:0];
    end else if (advY) begin
      xCur <= '0;
      yCur <= nextY[COORD_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Best-so-far tracking. Results are held through abort and IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bestCorr <= '0;
      xBest    <= '0;
      yBest    <= '0;
    end else if (sweepStart) begin
      bestCorr <= '0;
      xBest    <= '0;
      yBest    <= '0;
    end else if (capture && newBest) begin
      bestCorr <= corrBus.iCurrentCorr;
      xBest    <= xCur;
      yBest    <= yCur;
    end
  end

`ifdef CORR_SECOND_BEST_EN
  logic [CORR_W-1:0]  secondCorr;
  logic [COORD_W-1:0] xSecond;
  logic [COORD_W-1:0] ySecond;

  // When a new best arrives, the old best becomes the runner-up. Otherwise
  // the runner-up changes only when a value strictly beats it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      secondCorr <= '0;
      xSecond    <= '0;
      ySecond    <= '0;
    end else if (sweepStart) begin
      secondCorr <= '0;
      xSecond    <= '0;
      ySecond    <= '0;
    end else if (capture) begin
      if (newBest) begin
        secondCorr <= bestCorr;
        xSecond    <= xBest;
        ySecond    <= yBest;
      end else if (corrBus.iCurrentCorr > secondCorr) begin
        secondCorr <= corrBus.iCurrentCorr;
        xSecond    <= xCur;
        ySecond    <= yCur;
      end
    end
  end

  assign oSecondCorr = secondCorr;
  assign oXsecond    = xSecond;
  assign oYsecond    = ySecond;
`endif

  // ---------------------------------------------------------------------------
  // Heartbeat. The counter runs only while a sweep is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hbCnt <= '0;
    end else if (busy) begin
      hbCnt <= hbCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All are decoded from registered state, so they are 0 in reset.
  // ---------------------------------------------------------------------------
  assign corrBus.oCorrStart = (state == S_ISSUE);
  assign corrBus.oX         = xCur;
  assign corrBus.oY         = yCur;
  assign oBusy              = busy;
  assign oFinished          = (state == S_DONE);
  assign oXresult           = xBest;
  assign oYresult           = yBest;
  assign oBestCorr          = bestCorr;
  assign oStatusLed         = (state == S_DONE) || (busy && hbCnt[HB_BITS-1]);

endmodule
